// File: rtl/countdown_sequencer.sv
// Loads a BCD preset into a 4-digit countdown chain, paces the once-per-period borrow
// tick into the LS digit, and reports run/pause/expiry status to the game FSM.
module countdown_sequencer #(
    parameter int TICK_DIV    = 1000,
    parameter int LOAD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pause,
    input  logic        abort,
    input  logic [15:0] preset,
    input  logic [15:0] digits,
    output logic        reconfig,
    output logic [15:0] num_out,
    output logic        tick,
    output logic        running,
    output logic        paused,
    output logic        timeout
);

    localparam int PRESC_W = $clog2(TICK_DIV);
    localparam int LOAD_W  = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [LOAD_W-1:0]  LOAD_LAST  = LOAD_W'(LOAD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_RUN,
        S_PAUSED,
        S_EXPIRED
    } state_t;

    state_t              state_q, state_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [LOAD_W-1:0]   load_cnt_q, load_cnt_d;
    logic [15:0]         num_out_q, num_out_d;
    logic                tick_q, tick_d;
    logic                start_ok;

    // Cells only count 0..9, so out-of-range preset nibbles saturate at 9.
    function automatic logic [15:0] clamp_bcd(input logic [15:0] v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = (v[i*4 +: 4] > 4'd9) ? 4'd9 : v[i*4 +: 4];
        end
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        load_cnt_d = '0;
        num_out_d  = num_out_q;
        start_ok   = start && ((state_q == S_IDLE) || (state_q == S_PAUSED) ||
                               (state_q == S_EXPIRED));

        if (abort) begin
            state_d = S_IDLE;
            presc_d = '0;
        end else if (start_ok) begin
            num_out_d = clamp_bcd(preset);
            presc_d   = '0;
            state_d   = (preset == 16'h0000) ? S_EXPIRED : S_LOAD;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (load_cnt_q == LOAD_LAST) state_d = S_SETTLE;
                    else load_cnt_d = load_cnt_q + LOAD_W'(1);
                end
                S_SETTLE: begin
                    state_d = S_RUN;
                    presc_d = '0;
                end
                S_RUN: begin
                    // A tick already on the wire has consumed its period, even if paused now.
                    if (presc_q == PRESC_LAST) presc_d = '0;
                    else if (!pause) presc_d = presc_q + PRESC_W'(1);
                    if (pause) begin
                        state_d = S_PAUSED;
                    end else if (digits == 16'h0000) begin
                        state_d = S_EXPIRED;
                        presc_d = '0;
                    end
                end
                S_PAUSED: begin
                    if (pause) state_d = S_RUN;
                end
                default: ;
            endcase
        end

        // Registered one cycle ahead so tick is high exactly while the prescaler is terminal.
        tick_d = (state_d == S_RUN) && (presc_d == PRESC_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            load_cnt_q <= '0;
            num_out_q  <= '0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            load_cnt_q <= load_cnt_d;
            num_out_q  <= num_out_d;
            tick_q     <= tick_d;
        end
    end

    assign reconfig = (state_q == S_LOAD);
    assign running  = (state_q == S_RUN);
    assign paused   = (state_q == S_PAUSED);
    assign timeout  = (state_q == S_EXPIRED);
    assign tick     = tick_q;
    assign num_out  = num_out_q;

endmodule

// File: doc/countdown_sequencer.md
Name: countdown_sequencer

Overview:
Sequences a 4-digit BCD countdown chain of per-digit timer cells. It loads a preset into the chain through each cell's reconfig/numIn path and generates the once-per-second borrow tick into the least-significant digit. It also handles pause/resume and abort, detects expiry from the chain's digit values, and flags timeout to the game FSM.

Parameters:
TICK_DIV, 1000, clk cycles per countdown tick (≥2); prescaler width = clog2(TICK_DIV)
LOAD_CYCLES, 2, cycles reconfig is held high during a load (≥1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; begin countdown from preset
pause  in  1  one-cycle pulse; toggles RUN/PAUSED
abort  in  1  one-cycle pulse; return to IDLE
preset  in  16  BCD preset, [15:12] MS digit .. [3:0] LS digit
digits  in  16  live BCD counts from the chain, same packing
reconfig  out  1  load strobe to all digit cells
num_out  out  16  per-digit load values to the cells' numIn
tick  out  1  one-cycle borrow into the LS digit's borrowDown
running  out  1  high in RUN
paused  out  1  high in PAUSED
timeout  out  1  high in EXPIRED

Behaviour:
- Reset (rst=0 at clk edge): state IDLE, prescaler 0, load counter 0. All outputs 0, including num_out.
- States: IDLE, LOAD, SETTLE, RUN, PAUSED, EXPIRED. All outputs are registered or decoded from the registered state; no combinational path from inputs to outputs.
- Priority each cycle: abort > start > pause > internal events.
- abort in any state: next state IDLE, reconfig=0, tick=0, prescaler cleared, num_out retained.
- IDLE:
  - start with preset≠0: go to LOAD.
  - start with preset==0: go to EXPIRED.
  - pause ignored.
- Start capture: on an accepted start, num_out latches preset with each nibble clamped (nibble>9 becomes 9). num_out is stable through LOAD.
- LOAD:
  - reconfig=1 for exactly LOAD_CYCLES cycles, then SETTLE.
  - pause and start ignored.
- SETTLE: one cycle, reconfig=0, so the cells' borrow handshake resolves. Then RUN with prescaler=0.
- RUN:
  - Prescaler increments each cycle.
  - When prescaler==TICK_DIV-1: tick=1 for that cycle, prescaler wraps to 0.
  - digits==0 in RUN: next state EXPIRED. tick forced 0 that cycle even if the prescaler hits terminal; zero check wins.
  - pause: go to PAUSED. Prescaler holds its value; tick=0 in the pause cycle.
  - start ignored.
- PAUSED:
  - No ticks, prescaler frozen.
  - pause: return to RUN, prescaler resumes from the held value.
  - start: reload (go to LOAD with the new preset).
- EXPIRED:
  - timeout=1 held until leaving.
  - start: reload as in IDLE (preset==0 stays in EXPIRED).
  - pause ignored.
- Latency: start sampled at edge N gives reconfig high for cycles N+1..N+LOAD_CYCLES, SETTLE at N+LOAD_CYCLES+1, RUN from N+LOAD_CYCLES+2. First tick is TICK_DIV cycles into RUN.
- tick is never asserted outside RUN and never on two consecutive cycles.
- digits is treated as a trusted BCD input; no check of nibbles >9 on the digits input.

Test Plan:
1. TICK_DIV=4, LOAD_CYCLES=2. Reset, then start with preset=0x0003 → reconfig high 2 cycles, num_out=0x0003, running from cycle 4. Ticks every 4 cycles. Chain reads 0x0000 after the 3rd tick; timeout=1 on the next cycle, no 4th tick.
2. preset=0x0A1F → num_out=0x0919 (nibbles 0xA and 0xF clamped to 9).
3. RUN with prescaler=2, pause → paused=1, no ticks for 10 cycles. pause again → first tick after exactly 1 more cycle in RUN.
4. abort and start in the same cycle during RUN → IDLE, running=0, no reconfig.
5. start with preset=0x0000 from IDLE → timeout=1 next cycle, reconfig never asserted. Then start with preset=0x0100 → LOAD, timeout=0.
6. rst=0 mid-LOAD → all outputs 0 next cycle; with rst=1 and no start, the block stays IDLE.
